// File: rtl/exp_sum_buffer_pkg.sv
// Shared softmax definitions for the exponent-sum buffer.
//   state_t       : frame sequencing states
//   DEF_*         : default frame geometry
//   sum_size_for  : accumulator width that cannot overflow for a frame
//   index_width   : counter width able to address every frame element
package exp_sum_buffer_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    SUM_DONE = 2'd1,
    REPLAY   = 2'd2
  } state_t;

  localparam int DEF_DATA_SIZE      = 32;
  localparam int DEF_NUMBER_OF_DATA = 10;

  function automatic int sum_size_for(input int data_size, input int number_of_data);
    return data_size + $clog2(number_of_data);
  endfunction

  // A single-element frame still needs a one-bit counter.
  function automatic int index_width(input int number_of_data);
    return (number_of_data > 1) ? $clog2(number_of_data) : 1;
  endfunction

endpackage

// File: rtl/exp_sum_buffer_sat_accumulator.sv
// Saturating accumulator for the frame sum.
//   clock_i, reset_n_i : clock, async active-low reset
//   clear_i            : synchronous clear (wins over add_i)
//   add_i, value_i     : add zero-extended value_i this cycle
//   sum_o              : running sum, sticks at all-ones instead of wrapping
module exp_sum_buffer_sat_accumulator #(
  parameter int data_size = 32,
  parameter int sum_size  = 36
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 clear_i,
  input  logic                 add_i,
  input  logic [data_size-1:0] value_i,
  output logic [sum_size-1:0]  sum_o
);

  logic [sum_size-1:0] sum_q;
  logic [sum_size:0]   wide_sum;

  // One extra bit catches the carry that signals saturation.
  assign wide_sum = {1'b0, sum_q} + {{(sum_size + 1 - data_size){1'b0}}, value_i};

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (add_i) begin
      sum_q <= wide_sum[sum_size] ? {sum_size{1'b1}} : wide_sum[sum_size-1:0];
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/exp_sum_buffer.sv
// Exponent store / sum / replay buffer between the exp stage and the divider.
//   clock_i, reset_n_i         : clock, async active-low reset
//   exp_valid_i, exp_i         : incoming exponent stream of one frame
//   div_ready_i                : divider accepts the current element
//   div_valid_o, div_exp_o,
//   div_index_o, div_last_o    : replayed element (all zero while not valid)
//   div_sum_o                  : frozen frame sum, held until the next frame completes
//   sum_valid_o                : one-cycle pulse when the frame sum is final
//   overrun_o                  : sticky, exponent arrived while not collecting
//
// state    | meaning
// COLLECT  | storing exponents and accumulating their sum
// SUM_DONE | one cycle: sum final, pulse sum_valid_o, freeze it
// REPLAY   | present stored exponents to the divider in order
module exp_sum_buffer
  import exp_sum_buffer_pkg::*;
#(
  parameter int data_size      = DEF_DATA_SIZE,
  parameter int number_of_data = DEF_NUMBER_OF_DATA,
  parameter int sum_size       = sum_size_for(data_size, number_of_data)
) (
  input  logic                 clock_i,
  input  logic                 reset_n_i,
  input  logic                 exp_valid_i,
  input  logic [data_size-1:0] exp_i,
  input  logic                 div_ready_i,
  output logic                 div_valid_o,
  output logic [data_size-1:0] div_exp_o,
  output logic [sum_size-1:0]  div_sum_o,
  output logic [7:0]           div_index_o,
  output logic                 div_last_o,
  output logic                 sum_valid_o,
  output logic                 overrun_o
);

  localparam int idx_w = index_width(number_of_data);
  localparam int depth = 1 << idx_w;
  localparam logic [idx_w-1:0] last_idx = idx_w'(number_of_data - 1);

  state_t               state_q, state_d;
  logic [idx_w-1:0]     in_cnt_q, out_cnt_q;
  logic [data_size-1:0] buffer_q [depth];
  logic [sum_size-1:0]  acc_sum, sum_q;
  logic                 overrun_q;
  logic                 accept, xfer, last_xfer, overrun_set;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    xfer        = 1'b0;
    last_xfer   = 1'b0;
    overrun_set = 1'b0;
    unique case (state_q)
      COLLECT: begin
        if (exp_valid_i) begin
          accept = 1'b1;
          if (in_cnt_q == last_idx) state_d = SUM_DONE;
        end
      end
      SUM_DONE: begin
        overrun_set = exp_valid_i;
        state_d     = REPLAY;
      end
      REPLAY: begin
        overrun_set = exp_valid_i;
        if (div_ready_i) begin
          xfer = 1'b1;
          if (out_cnt_q == last_idx) begin
            last_xfer = 1'b1;
            state_d   = COLLECT;
          end
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= COLLECT;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) in_cnt_q <= (in_cnt_q == last_idx) ? '0 : in_cnt_q + idx_w'(1);
      if (state_q == SUM_DONE) begin
        out_cnt_q <= '0;
        sum_q     <= acc_sum;
      end else if (xfer) begin
        out_cnt_q <= last_xfer ? '0 : out_cnt_q + idx_w'(1);
      end
      if (overrun_set) overrun_q <= 1'b1;
    end
  end

  // Storage needs no reset: only entries written this frame are ever read.
  always_ff @(posedge clock_i) begin
    if (accept) buffer_q[in_cnt_q] <= exp_i;
  end

  exp_sum_buffer_sat_accumulator #(
    .data_size(data_size),
    .sum_size (sum_size)
  ) u_acc (
    .clock_i  (clock_i),
    .reset_n_i(reset_n_i),
    .clear_i  (last_xfer),
    .add_i    (accept),
    .value_i  (exp_i),
    .sum_o    (acc_sum)
  );

  assign div_valid_o = (state_q == REPLAY);
  assign sum_valid_o = (state_q == SUM_DONE);
  assign div_exp_o   = div_valid_o ? buffer_q[out_cnt_q] : '0;
  assign div_index_o = div_valid_o ? 8'(out_cnt_q) : 8'd0;
  assign div_last_o  = div_valid_o && (out_cnt_q == last_idx);
  // The accumulator already holds the final sum during SUM_DONE, so the
  // sum is visible together with its pulse rather than a cycle later.
  assign div_sum_o   = (state_q == SUM_DONE) ? acc_sum : sum_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_exp_sum_buffer.sv
module tb_exp_sum_buffer;

  typedef struct packed {
    logic [31:0] e;
    logic [31:0] eb;
    logic [7:0]  idx;
    logic        last;
    logic [35:0] sa;
    logic [32:0] sb;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exp_valid = 1'b0;
  logic [31:0] exp_val = '0;
  logic        div_ready = 1'b0;

  logic        a_valid, a_last, a_sv, a_ovr;
  logic [31:0] a_exp;
  logic [35:0] a_sum;
  logic [7:0]  a_idx;
  logic        b_valid, b_last, b_sv, b_ovr;
  logic [31:0] b_exp;
  logic [32:0] b_sum;
  logic [7:0]  b_idx;

  always #5 clk = ~clk;

  exp_sum_buffer #(.data_size(32), .number_of_data(10)) dut_a (
    .clock_i(clk), .reset_n_i(rst_n), .exp_valid_i(exp_valid), .exp_i(exp_val),
    .div_ready_i(div_ready), .div_valid_o(a_valid), .div_exp_o(a_exp), .div_sum_o(a_sum),
    .div_index_o(a_idx), .div_last_o(a_last), .sum_valid_o(a_sv), .overrun_o(a_ovr));

  // Narrow accumulator copy to exercise saturation on the same stimulus.
  exp_sum_buffer #(.data_size(32), .number_of_data(10), .sum_size(33)) dut_b (
    .clock_i(clk), .reset_n_i(rst_n), .exp_valid_i(exp_valid), .exp_i(exp_val),
    .div_ready_i(div_ready), .div_valid_o(b_valid), .div_exp_o(b_exp), .div_sum_o(b_sum),
    .div_index_o(b_idx), .div_last_o(b_last), .sum_valid_o(b_sv), .overrun_o(b_ovr));

  int checks = 0;
  int failures = 0;

  logic [31:0] stim_q[$];
  xfer_t       exp_q[$];
  xfer_t       got_q[$];
  longint unsigned exp_sa, exp_sb;

  int cyc = 0, last_in_cyc, sv_cnt, sv_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc;
  int stall_err, zero_err, b_err;
  logic [35:0] sv_sum_a;
  logic [32:0] sv_sum_b;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
  logic [31:0] p_exp = '0;
  logic [7:0]  p_idx = '0;
  xfer_t       mt;

  // Observer only: records transfers, pulses and protocol anomalies.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (exp_valid) last_in_cyc = cyc;
      if (a_sv) begin
        sv_cnt++; sv_cyc = cyc; sv_sum_a = a_sum; sv_sum_b = b_sum;
      end
      if (a_valid && !p_valid) first_valid_cyc = cyc;
      if (a_valid && div_ready) begin
        if (got_q.size() == 0) first_xfer_cyc = cyc;
        last_xfer_cyc = cyc;
        mt.e = a_exp; mt.eb = b_exp; mt.idx = a_idx; mt.last = a_last;
        mt.sa = a_sum; mt.sb = b_sum;
        got_q.push_back(mt);
      end
      if (p_valid && !p_ready &&
          (!a_valid || a_exp !== p_exp || a_idx !== p_idx || a_last !== p_last)) stall_err++;
      if (!a_valid && (a_exp !== 32'd0 || a_idx !== 8'd0 || a_last !== 1'b0)) zero_err++;
      if (a_valid !== b_valid || a_sv !== b_sv || a_exp !== b_exp ||
          a_idx !== b_idx || a_last !== b_last) b_err++;
    end
    p_valid = a_valid; p_ready = div_ready; p_exp = a_exp; p_idx = a_idx; p_last = a_last;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    sv_cnt = 0; sv_cyc = -1; first_valid_cyc = -1; last_in_cyc = -100;
    first_xfer_cyc = -1; last_xfer_cyc = -1;
    stall_err = 0; zero_err = 0; b_err = 0;
  endtask

  // Reference model: the frame sum is plain arithmetic clamped to each width,
  // and the replay is simply the input sequence in order.
  task automatic build_expected();
    longint unsigned s = 0;
    xfer_t t;
    exp_q.delete();
    foreach (stim_q[i]) s += longint'(stim_q[i]);
    exp_sa = (s > 64'h0000_000F_FFFF_FFFF) ? 64'h0000_000F_FFFF_FFFF : s;
    exp_sb = (s > 64'h0000_0001_FFFF_FFFF) ? 64'h0000_0001_FFFF_FFFF : s;
    foreach (stim_q[i]) begin
      t.e = stim_q[i]; t.eb = stim_q[i]; t.idx = 8'(i);
      t.last = (i == stim_q.size() - 1);
      t.sa = exp_sa[35:0]; t.sb = exp_sb[32:0];
      exp_q.push_back(t);
    end
  endtask

  task automatic send_frame(input int gap_fixed, input int gap_rand);
    int gap;
    foreach (stim_q[i]) begin
      exp_valid = 1'b1; exp_val = stim_q[i];
      tick();
      exp_valid = 1'b0; exp_val = $urandom;
      gap = gap_fixed + ((gap_rand > 0) ? int'($urandom_range(gap_rand, 0)) : 0);
      repeat (gap) tick();
    end
  endtask

  // mode 0: ready always, 1: ready toggles 1010.., 2: random ready.
  // inject 1: stray exponent mid-replay, 2: stray exponent on the last transfer.
  task automatic replay(input int mode, input int inject);
    int budget = 400;
    bit injected = 1'b0;
    bit tog = 1'b1;
    while (got_q.size() < stim_q.size() && budget > 0) begin
      case (mode)
        0: div_ready = 1'b1;
        1: begin div_ready = tog; tog = !tog; end
        default: div_ready = 1'($urandom_range(1, 0));
      endcase
      exp_valid = 1'b0;
      if (inject == 1 && !injected && a_valid && a_idx == 8'd3) begin
        exp_valid = 1'b1; exp_val = 32'hDEAD_BEEF; injected = 1'b1;
      end
      if (inject == 2 && a_valid && a_last && div_ready) begin
        exp_valid = 1'b1; exp_val = 32'h0BAD_F00D;
      end
      tick();
      budget--;
    end
    div_ready = 1'b0; exp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({a_valid, a_sv, a_ovr, a_last, a_idx, a_exp, a_sum} !== '0 ||
        {b_valid, b_sv, b_ovr, b_last, b_idx, b_exp, b_sum} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got a_valid=%0b a_exp=%h a_sum=%h b_sum=%h ovr=%0b required all zero",
               a_valid, a_exp, a_sum, b_sum, a_ovr);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_mon();
    stim_q.delete();
    for (int i = 1; i <= 10; i++) stim_q.push_back(32'(i));
    build_expected();
    send_frame(0, 0);
    replay(0, 0);
    checks++;
    if (sv_cnt != 1 || sv_cyc - last_in_cyc != 1) begin
      failures++;
      $display("FAIL basic_sum_valid_latency got count=%0d latency=%0d required count=1 latency=1",
               sv_cnt, sv_cyc - last_in_cyc);
    end
    checks++;
    if (first_valid_cyc - last_in_cyc != 2) begin
      failures++;
      $display("FAIL basic_div_valid_latency got %0d required 2", first_valid_cyc - last_in_cyc);
    end
    checks++;
    if (sv_sum_a !== 36'd55) begin
      failures++;
      $display("FAIL basic_sum_at_pulse got %h required %h", sv_sum_a, 36'd55);
    end
    checks++;
    if (got_q.size() != exp_q.size() || last_xfer_cyc - first_xfer_cyc != 9) begin
      failures++;
      $display("FAIL basic_throughput got %0d transfers over %0d cycles required 10 over 9",
               got_q.size(), last_xfer_cyc - first_xfer_cyc);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL basic_xfer[%0d] got exp=%h idx=%0d last=%0b sum=%h required exp=%h idx=%0d last=%0b sum=%h",
                 i, got_q[i].e, got_q[i].idx, got_q[i].last, got_q[i].sa,
                 exp_q[i].e, exp_q[i].idx, exp_q[i].last, exp_q[i].sa);
      end
    end
    checks++;
    if (stall_err != 0 || zero_err != 0 || b_err != 0 || a_valid !== 1'b0 || a_ovr !== 1'b0) begin
      failures++;
      $display("FAIL basic_protocol got stall=%0d zero=%0d cross=%0d valid_after=%0b overrun=%0b required 0 0 0 0 0",
               stall_err, zero_err, b_err, a_valid, a_ovr);
    end
  endtask

  task automatic test_toggle_ready();
    clear_mon();
    stim_q.delete();
    for (int i = 1; i <= 10; i++) stim_q.push_back(32'(i));
    build_expected();
    send_frame(0, 0);
    replay(1, 0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL toggle_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL toggle_xfer[%0d] got exp=%h idx=%0d sum=%h required exp=%h idx=%0d sum=%h",
                 i, got_q[i].e, got_q[i].idx, got_q[i].sa, exp_q[i].e, exp_q[i].idx, exp_q[i].sa);
      end
    end
    checks++;
    if (stall_err != 0 || zero_err != 0 || b_err != 0 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL toggle_protocol got stall=%0d zero=%0d cross=%0d valid_after=%0b required 0 0 0 0",
               stall_err, zero_err, b_err, a_valid);
    end
  endtask

  task automatic test_gapped();
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back(32'h100);
    build_expected();
    send_frame(2, 0);
    replay(0, 0);
    checks++;
    if (sv_cnt != 1 || sv_cyc - last_in_cyc != 1 || sv_sum_a !== 36'hA00) begin
      failures++;
      $display("FAIL gapped_sum_pulse got count=%0d latency=%0d sum=%h required 1 1 a00",
               sv_cnt, sv_cyc - last_in_cyc, sv_sum_a);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL gapped_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL gapped_xfer[%0d] got exp=%h sum=%h required exp=%h sum=%h",
                 i, got_q[i].e, got_q[i].sa, exp_q[i].e, exp_q[i].sa);
      end
    end
  endtask

  task automatic test_saturate();
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back(32'hFFFF_FFFF);
    build_expected();
    send_frame(0, 0);
    replay(2, 0);
    checks++;
    if (sv_sum_b !== 33'h1_FFFF_FFFF || sv_sum_a !== 36'h9_FFFF_FFF6) begin
      failures++;
      $display("FAIL saturate_sum got narrow=%h wide=%h required narrow=1ffffffff wide=9fffffff6",
               sv_sum_b, sv_sum_a);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL saturate_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL saturate_xfer[%0d] got exp=%h expb=%h sumb=%h required exp=%h expb=%h sumb=%h",
                 i, got_q[i].e, got_q[i].eb, got_q[i].sb, exp_q[i].e, exp_q[i].eb, exp_q[i].sb);
      end
    end
    checks++;
    if (stall_err != 0 || zero_err != 0 || b_err != 0) begin
      failures++;
      $display("FAIL saturate_protocol got stall=%0d zero=%0d cross=%0d required 0 0 0",
               stall_err, zero_err, b_err);
    end
  endtask

  task automatic test_overrun_replay();
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back($urandom);
    build_expected();
    send_frame(0, 1);
    replay(2, 1);
    checks++;
    if (a_ovr !== 1'b1 || b_ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_set got a=%0b b=%0b required 1 1", a_ovr, b_ovr);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL overrun_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL overrun_xfer[%0d] got exp=%h sum=%h required exp=%h sum=%h",
                 i, got_q[i].e, got_q[i].sa, exp_q[i].e, exp_q[i].sa);
      end
    end
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back(32'd2);
    build_expected();
    send_frame(0, 0);
    replay(0, 0);
    checks++;
    if (got_q.size() != 10 || got_q[got_q.size()-1].sa !== 36'd20 || got_q[0].e !== 32'd2) begin
      failures++;
      $display("FAIL overrun_next_frame got count=%0d required 10 with sum 20 and first 2", got_q.size());
    end
    checks++;
    if (a_ovr !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky got %0b required 1", a_ovr);
    end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    stim_q.delete();
    repeat (5) stim_q.push_back(32'd7);
    send_frame(0, 0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_valid, a_sv, a_ovr, a_last, a_idx, a_exp, a_sum} !== '0 || b_ovr !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset_outputs got valid=%0b sum=%h ovr=%0b required all zero",
               a_valid, a_sum, a_ovr);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back(32'd3);
    build_expected();
    send_frame(0, 0);
    replay(0, 0);
    checks++;
    if (sv_cnt != 1 || sv_sum_a !== 36'd30) begin
      failures++;
      $display("FAIL midframe_next_sum got count=%0d sum=%h required 1 and %h", sv_cnt, sv_sum_a, 36'd30);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL midframe_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL midframe_xfer[%0d] got exp=%h idx=%0d sum=%h required exp=%h idx=%0d sum=%h",
                 i, got_q[i].e, got_q[i].idx, got_q[i].sa, exp_q[i].e, exp_q[i].idx, exp_q[i].sa);
      end
    end
  endtask

  task automatic test_last_overrun();
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back($urandom_range(32'h00FF_FFFF, 0));
    build_expected();
    send_frame(0, 0);
    checks++;
    if (a_ovr !== 1'b0) begin
      failures++;
      $display("FAIL last_overrun_pre got %0b required 0", a_ovr);
    end
    replay(0, 2);
    checks++;
    if (a_ovr !== 1'b1 || a_valid !== 1'b0) begin
      failures++;
      $display("FAIL last_overrun_set got ovr=%0b valid=%0b required 1 0", a_ovr, a_valid);
    end
    clear_mon();
    stim_q.delete();
    repeat (10) stim_q.push_back(32'd5);
    build_expected();
    send_frame(0, 0);
    replay(0, 0);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL last_overrun_count got %0d required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL last_overrun_xfer[%0d] got exp=%h sum=%h required exp=%h sum=%h",
                 i, got_q[i].e, got_q[i].sa, exp_q[i].e, exp_q[i].sa);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      clear_mon();
      stim_q.delete();
      repeat (10) stim_q.push_back(($urandom_range(1, 0) == 1) ? $urandom : $urandom_range(1000, 0));
      build_expected();
      send_frame(0, 3);
      replay(2, 0);
      checks++;
      if (got_q.size() != exp_q.size() || sv_cnt != 1) begin
        failures++;
        $display("FAIL random_count frame %0d got xfers=%0d pulses=%0d required %0d 1",
                 f, got_q.size(), sv_cnt, exp_q.size());
      end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL random_xfer f%0d[%0d] got exp=%h idx=%0d suma=%h sumb=%h required exp=%h idx=%0d suma=%h sumb=%h",
                   f, i, got_q[i].e, got_q[i].idx, got_q[i].sa, got_q[i].sb,
                   exp_q[i].e, exp_q[i].idx, exp_q[i].sa, exp_q[i].sb);
        end
      end
      checks++;
      if (stall_err != 0 || zero_err != 0 || b_err != 0) begin
        failures++;
        $display("FAIL random_protocol frame %0d got stall=%0d zero=%0d cross=%0d required 0 0 0",
                 f, stall_err, zero_err, b_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_ready();
    test_gapped();
    test_saturate();
    test_overrun_replay();
    test_reset_midframe();
    test_last_overrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got still running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exp_sum_buffer.md
Name: exp_sum_buffer

Overview:
- Sits directly downstream of the exponent stage in the softmax COMPUTE path; consumes the exp_valid/exp stream of one frame (number_of_data values).
- Stores every exponent, accumulates their sum, then replays each stored exponent together with the frozen sum to the divider stage through a valid/ready handshake.
- One frame in flight; returns to collecting after the last replayed element is accepted.

Parameters:
- data_size, 32, width of each exponent value (unsigned fixed-point, format passed through untouched)
- number_of_data, 10, exponents per frame (1..255)
- sum_size, 36, accumulator width; must be >= data_size + ceil(log2(number_of_data))

Ports:
- clock_i  input  1  single clock, rising edge
- reset_n_i  input  1  asynchronous active-low reset
- exp_valid_i  input  1  exponent strobe from exp stage, one-cycle pulses
- exp_i  input  data_size  exponent value, sampled when exp_valid_i=1
- div_ready_i  input  1  divider can accept current element
- div_valid_o  output  1  replay element valid
- div_exp_o  output  data_size  replayed exponent (numerator)
- div_sum_o  output  sum_size  frame sum (denominator), constant for whole replay
- div_index_o  output  8  element index 0..number_of_data-1 of div_exp_o
- div_last_o  output  1  high with the final element of the frame
- sum_valid_o  output  1  one-cycle pulse when the frame sum is final
- overrun_o  output  1  sticky: exp_valid_i seen outside COLLECT

Behaviour:
- Reset (async assert, sync-released usage): state=COLLECT, counters=0, accumulator=0, buffer contents don't-care, all outputs 0.
- States: COLLECT, SUM_DONE, REPLAY.
- COLLECT: on exp_valid_i, buffer[in_cnt]<=exp_i, acc<=acc+exp_i (zero-extended), in_cnt++. When accepting element number_of_data-1, next state SUM_DONE.
- Accumulator saturates at all-ones of sum_size; never wraps.
- SUM_DONE: one cycle; sum_valid_o=1, div_sum_o latched = acc; out_cnt=0; next REPLAY.
- Latency: sum_valid_o rises exactly 1 cycle after the final exp_valid_i cycle; div_valid_o rises 2 cycles after it.
- REPLAY: div_valid_o=1, div_exp_o=buffer[out_cnt], div_index_o=out_cnt, div_last_o=(out_cnt==number_of_data-1).
- Handshake: transfer when div_valid_o && div_ready_i; outputs hold stable while div_ready_i=0; div_valid_o never drops without a transfer.
- On transfer with div_last_o=1: next state COLLECT, acc<=0, in_cnt<=0, div_valid_o=0 next cycle; div_sum_o holds its value until next SUM_DONE.
- Back-to-back: transfers every cycle when div_ready_i held high (throughput 1/cycle).
- exp_valid_i during SUM_DONE or REPLAY: value dropped, buffer/acc unchanged, overrun_o<=1 (cleared only by reset).
- exp_valid_i in the same cycle the last element transfers (state still REPLAY): dropped, overrun set.
- number_of_data=1: COLLECT->SUM_DONE->REPLAY with single element, div_last_o=1 on it.
- Reset mid-frame (any state): immediate return to reset values; partial frame discarded.
- No X on outputs while div_valid_o=0: div_exp_o, div_index_o, div_last_o driven 0.

Decomposition:
- Shared softmax package: state encodings (COLLECT=0, SUM_DONE=1, REPLAY=2), default data_size/number_of_data, sum_size derivation helper (clog2).
- One natural sub-module: sat_accumulator (zero-extend, add, saturate, synchronous clear), instanced once.
- Buffer as simple register array inside the block.

Test Plan:
- Frame 1..10 (exp_i=1,2,...,10 every cycle), div_ready_i=1 -> sum_valid_o pulse 1 cycle after last input, div_sum_o=55, replay 1..10 in 10 consecutive cycles, div_last_o on index 9.
- Same frame with div_ready_i toggling 1010... -> each element held stable until accepted, order unchanged, 10 transfers, div_sum_o=55 throughout.
- Gapped input (exp_valid_i every 3rd cycle, values 0x100) -> sum 0xA00, no premature sum_valid_o.
- Ten inputs of 0xFFFFFFFF with sum_size=33 -> div_sum_o saturates to 0x1_FFFFFFFF, replay values intact.
- exp_valid_i pulsed during REPLAY -> overrun_o=1 sticky, replay data and sum unaffected; next frame of ten 2s gives sum 20.
- Reset asserted after 5 inputs and released -> all outputs 0; new frame of ten 3s gives sum 30 (no residue).
